epl_serial_master: RTL

EPL_SERIAL_MASTER -- requirements
Module: epl_serial_master

---
 rtl/epl_serial_master.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/epl_serial_master.sv
// epl_serial_master: single-frame serial bus master.
// A frame is an 8-bit command {rnw, addr} followed by 32 data bits, MSB first.
// Each bit is EPL_SCLK high for CLK_DIV cycles and then low for CLK_DIV cycles.
// EPL_SLE frames the whole transfer. EPL_SRDY gates the data phase.
// Optional feature: define EPL_MASTER_TIMEOUT_EN to abort a frame that waits
// too long for EPL_SRDY. Such a frame completes with err=1.
module epl_serial_master #(
  parameter int CLK_DIV        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        PLD_MCLK,
  input  logic        EPL_RESETN,
  input  logic        start,
  input  logic        rnw,
  input  logic [6:0]  addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        EPL_SCLK,
  output logic        EPL_SDI,
  input  logic        EPL_SDO,
  output logic        EPL_SLE,
  input  logic        EPL_SRDY
);

  if (CLK_DIV < 2 || CLK_DIV > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("epl_serial_master: CLK_DIV must be 2..255 and TIMEOUT_CYCLES >= 1");
  end

  localparam logic [7:0] DIV_N  = 8'(CLK_DIV);
  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, CMD, WAIT_RDY, DATA, HOLD, DONE
  } state_t;

  state_t      r_state;
  logic [7:0]  r_div_cnt;   // cycles left in the current half-period
  logic [5:0]  r_bit_cnt;   // falling edges so far in this frame, 0..40
  logic [39:0] r_shift;     // {command, write data}; the MSB is the next bit out
  logic [31:0] r_rx;
  logic        r_rnw;
  logic        r_pending;   // start accepted, SETUP still held off by the SLE gap
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_rdata;
  logic        r_sclk;
  logic        r_sdi;
  logic        r_sle;
  logic [7:0]  r_gap_cnt;   // SLE-low cycles since the last frame, saturating
  logic        r_srdy_meta;
  logic        r_srdy_sync;

  logic w_accept;
  logic w_gap_ok;
  logic w_half_end;

  assign w_accept   = start && !r_busy;
  assign w_gap_ok   = (r_gap_cnt == DIV_N);
  assign w_half_end = (r_div_cnt == 8'd0);

`ifdef EPL_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign busy     = r_busy;
  assign done     = r_done;
  assign rdata    = r_rdata;
  assign EPL_SCLK = r_sclk;
  assign EPL_SDI  = r_sdi;
  assign EPL_SLE  = r_sle;

  // Two-flop synchroniser for the asynchronous slave-ready input.
  always_ff @(posedge PLD_MCLK or negedge EPL_RESETN) begin
    if (!EPL_RESETN) begin
      r_srdy_meta <= 1'b0;
      r_srdy_sync <= 1'b0;
    end else begin
      r_srdy_meta <= EPL_SRDY;
      r_srdy_sync <= r_srdy_meta;
    end
  end

  // Count SLE-low cycles. Reset presets the count so that the first frame
  // does not wait.
  always_ff @(posedge PLD_MCLK or negedge EPL_RESETN) begin
    if (!EPL_RESETN) begin
      r_gap_cnt <= DIV_N;
    end else if (r_sle) begin
      r_gap_cnt <= 8'd0;
    end else if (r_gap_cnt != DIV_N) begin
      r_gap_cnt <= r_gap_cnt + 8'd1;
    end
  end

  // Frame FSM. All bus pins and handshake outputs are registered here.
  always_ff @(posedge PLD_MCLK or negedge EPL_RESETN) begin
    if (!EPL_RESETN) begin
      // NOTE: the shift registers are cleared along with the control state.
      // After reset the outputs and rdata are then defined, and no stale data
      // can leak into the next frame.
      r_state   <= IDLE;
      r_div_cnt <= 8'd0;
      r_bit_cnt <= 6'd0;
      r_shift   <= 40'd0;
      r_rx      <= 32'd0;
      r_rnw     <= 1'b0;
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rdata   <= 32'd0;
      r_sclk    <= 1'b0;
      r_sdi     <= 1'b0;
      r_sle     <= 1'b0;
`ifdef EPL_MASTER_TIMEOUT_EN
      r_to_cnt  <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments mean that a later assignment in this
      // block overrides an earlier one. The done pulse therefore defaults low
      // here, and the accept block runs before the case statement, so the case
      // statement has the final say on r_pending.
      r_done <= 1'b0;

      if (w_accept) begin
        r_rnw     <= rnw;
        r_shift   <= {rnw, addr, (rnw ? 32'd0 : wdata)};
        r_busy    <= 1'b1;
        r_pending <= 1'b1;
`ifdef EPL_MASTER_TIMEOUT_EN
        r_err     <= 1'b0;
`endif
      end

      case (r_state)
        IDLE: begin
          if ((r_pending || w_accept) && w_gap_ok) begin
            r_state   <= SETUP;
            r_pending <= 1'b0;
            r_sle     <= 1'b1;
            r_sclk    <= 1'b0;
            r_sdi     <= w_accept ? rnw : r_shift[39];
            r_div_cnt <= DIV_M1;
            r_bit_cnt <= 6'd0;
          end
        end

        SETUP: begin
          if (w_half_end) begin
            r_state   <= CMD;
            r_sclk    <= 1'b1;
            r_div_cnt <= DIV_M1;
          end else begin
            r_div_cnt <= r_div_cnt - 8'd1;
          end
        end

        CMD, DATA: begin
          if (!w_half_end) begin
            r_div_cnt <= r_div_cnt - 8'd1;
          end else if (r_sclk) begin
            // Falling edge: the only point at which EPL_SDI moves on.
            r_sclk    <= 1'b0;
            r_sdi     <= r_shift[38];
            r_shift   <= {r_shift[38:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 6'd1;
            r_div_cnt <= DIV_M1;
          end else if (r_state == CMD && r_bit_cnt == 6'd8) begin
            r_state <= WAIT_RDY;
`ifdef EPL_MASTER_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
          end else if (r_state == DATA && r_bit_cnt == 6'd40) begin
            r_state   <= HOLD;
            r_div_cnt <= DIV_M1;
          end else begin
            // Rising edge: EPL_SDO is sampled in this same cycle.
            r_sclk    <= 1'b1;
            r_div_cnt <= DIV_M1;
            if (r_state == DATA && r_rnw) begin
              r_rx <= {r_rx[30:0], EPL_SDO};
            end
          end
        end

        WAIT_RDY: begin
          if (r_srdy_sync) begin
            // Leaving the wait starts data bit 31 with its rising edge.
            r_state   <= DATA;
            r_sclk    <= 1'b1;
            r_div_cnt <= DIV_M1;
            if (r_rnw) begin
              r_rx <= {r_rx[30:0], EPL_SDO};
            end
          end
`ifdef EPL_MASTER_TIMEOUT_EN
          else if (r_to_cnt == TO_LAST) begin
            r_state <= DONE;
            r_sle   <= 1'b0;
            r_sdi   <= 1'b0;
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end

        HOLD: begin
          if (w_half_end) begin
            r_state <= DONE;
            r_sle   <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            if (r_rnw) begin
              r_rdata <= r_rx;
            end
          end else begin
            r_div_cnt <= r_div_cnt - 8'd1;
          end
        end

        DONE: r_state <= IDLE;

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
